// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_pkg
//   Shared definitions for the ALU op sequencer:
//     - ALU op codes (OP_*), 5 bits wide to match the control FSM aluOP field
//     - default multi-cycle latencies for divide and multiply
//     - sequencer state encoding (STATE_SEQ_*)
//   Codes 5'h0E..5'h1F are unassigned. The sequencer treats them as illegal.
// ---------------------------------------------------------------------------
package alu_op_sequencer_pkg;

  localparam int OP_W = 5;

  // Single-cycle ALU ops.
  localparam logic [OP_W-1:0] OP_ADD      = 5'h00;
  localparam logic [OP_W-1:0] OP_SUB      = 5'h01;
  localparam logic [OP_W-1:0] OP_AND      = 5'h02;
  localparam logic [OP_W-1:0] OP_OR       = 5'h03;
  localparam logic [OP_W-1:0] OP_XOR      = 5'h04;
  localparam logic [OP_W-1:0] OP_NOR      = 5'h05;
  localparam logic [OP_W-1:0] OP_SLL      = 5'h06;
  localparam logic [OP_W-1:0] OP_SRL      = 5'h07;
  localparam logic [OP_W-1:0] OP_SRA      = 5'h08;
  localparam logic [OP_W-1:0] OP_SLT      = 5'h09;
  localparam logic [OP_W-1:0] OP_SLTU     = 5'h0A;
  localparam logic [OP_W-1:0] OP_LUI      = 5'h0B;

  // Multi-cycle ALU ops.
  localparam logic [OP_W-1:0] OP_MULTIPLY = 5'h0C;
  localparam logic [OP_W-1:0] OP_DIVIDE   = 5'h0D;

  // Default latencies, in ALU cycles.
  localparam int DIV_LATENCY_DEF = 16;
  localparam int MUL_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    STATE_SEQ_IDLE = 2'd0,
    STATE_SEQ_EXEC = 2'd1,
    STATE_SEQ_WB   = 2'd2
  } seq_state_e;

endpackage : alu_op_sequencer_pkg

// File: rtl/alu_op_sequencer_lat.sv
// ---------------------------------------------------------------------------
// alu_lat_counter
//   Down-counter that tracks the ALU cycles remaining for the op in flight.
//   Reaching zero tells the sequencer that the current EXEC cycle is the last.
//   The counter stops at zero and never wraps.
//
// Ports
//   clk         in  clock, all logic on posedge
//   reset       in  synchronous, active-low reset (clears count)
//   clear       in  abandon the current count (flush)
//   load        in  load load_value (takes priority over dec)
//   load_value  in  CNT_BITS, value to load (latency - 1)
//   dec         in  decrement by one, saturating at zero
//   zero        out count == 0
// ---------------------------------------------------------------------------
module alu_lat_counter #(
  parameter int CNT_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_value,
  input  logic                dec,
  output logic                zero
);

  logic [CNT_BITS-1:0] count;

  // NOTE: reset is sampled only at posedge clk, so it sits inside the clocked
  // block and is absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule : alu_lat_counter

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Issues ALU ops on behalf of the multi-cycle control FSM. The sequencer
//   accepts one op per valid/ready handshake. It holds alu_op stable for the
//   op's latency, then pulses write_enable for one cycle so the register
//   file can write back. The control FSM stalls while req_ready is low.
//
//   Timeline for an op accepted at cycle N with latency L:
//     EXEC  N+1 .. N+L  (alu_start in N+1)
//     WB    N+L+1       (write_enable, wr_addr)
//     next accept no earlier than N+L+2
//   An unknown op is accepted. It pulses illegal_op in N+1 and stays IDLE.
//
// Ports
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous, active-low reset
//   flush         in   abort current op, no writeback
//   req_valid     in   control FSM presents an op
//   req_ready     out  sequencer can accept (IDLE and !flush)
//   req_op        in   OP_BITS, ALU op code (OP_*)
//   req_rd        in   RD_BITS, destination register
//   alu_op        out  OP_BITS, op driven to ALU, stable through EXEC
//   alu_start     out  one-cycle pulse, first EXEC cycle
//   write_enable  out  one-cycle register write strobe (WB)
//   wr_addr       out  RD_BITS, destination for write_enable
//   busy          out  high in EXEC and WB
//   illegal_op    out  one-cycle pulse after an unknown op is accepted
//   perf_busy     out  [31:0] cycles with busy=1   (ALU_SEQ_PERF_EN only)
//   perf_ops      out  [15:0] ops reaching WB      (ALU_SEQ_PERF_EN only)
//
// Configuration
//   ALU_SEQ_PERF_EN  when defined, adds the saturating perf_busy/perf_ops
//                    counters. Reset clears them and flush does not.
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int OP_BITS     = OP_W,
  parameter int RD_BITS     = 3,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int CNT_BITS    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_BITS-1:0] req_op,
  input  logic [RD_BITS-1:0] req_rd,
  output logic [OP_BITS-1:0] alu_op,
  output logic               alu_start,
  output logic               write_enable,
  output logic [RD_BITS-1:0] wr_addr,
  output logic               busy,
  output logic               illegal_op
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_busy,
  output logic [15:0]        perf_ops
`endif
);

  seq_state_e          state;
  logic                accept;
  logic                req_known;
  logic [CNT_BITS-1:0] req_load;
  logic                cnt_zero;

  // ------------------------------------------------------------------------
  // Latency lookup: the counter is loaded with latency-1, so a single-cycle
  // op loads zero and leaves EXEC after one cycle.
  // ------------------------------------------------------------------------
  // NOTE: each output of a combinational block gets a default value first.
  // That way no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_known = 1'b1;
    req_load  = '0;
    case (req_op)
      OP_BITS'(OP_DIVIDE):   req_load = CNT_BITS'(DIV_LATENCY - 1);
      OP_BITS'(OP_MULTIPLY): req_load = CNT_BITS'(MUL_LATENCY - 1);
      OP_BITS'(OP_ADD),
      OP_BITS'(OP_SUB),
      OP_BITS'(OP_AND),
      OP_BITS'(OP_OR),
      OP_BITS'(OP_XOR),
      OP_BITS'(OP_NOR),
      OP_BITS'(OP_SLL),
      OP_BITS'(OP_SRL),
      OP_BITS'(OP_SRA),
      OP_BITS'(OP_SLT),
      OP_BITS'(OP_SLTU),
      OP_BITS'(OP_LUI):      req_load = '0;
      default:               req_known = 1'b0;
    endcase
  end

  // flush blocks acceptance in the same cycle. An op offered with flush is
  // simply not taken.
  assign req_ready = (state == STATE_SEQ_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  // Flush wins over writeback even in the WB cycle itself. For that reason
  // the strobe is gated combinationally rather than registered.
  assign write_enable = (state == STATE_SEQ_WB) && !flush;

  // ------------------------------------------------------------------------
  // Latency counter
  // ------------------------------------------------------------------------
  alu_lat_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .load       (accept && req_known),
    .load_value (req_load),
    .dec        (state == STATE_SEQ_EXEC),
    .zero       (cnt_zero)
  );

  // ------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ------------------------------------------------------------------------
  // NOTE: state and registered outputs use non-blocking assignments. Every
  // register then updates from the same pre-edge values, and the result
  // does not depend on statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= STATE_SEQ_IDLE;
      alu_op     <= '0;
      wr_addr    <= '0;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      alu_start  <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        STATE_SEQ_IDLE: begin
          if (accept) begin
            alu_op  <= req_op;
            wr_addr <= req_rd;
            if (req_known) begin
              state     <= STATE_SEQ_EXEC;
              alu_start <= 1'b1;
              busy      <= 1'b1;
            end else begin
              illegal_op <= 1'b1;
            end
          end
        end
        STATE_SEQ_EXEC: begin
          if (flush) begin
            state <= STATE_SEQ_IDLE;
            busy  <= 1'b0;
          end else if (cnt_zero) begin
            state <= STATE_SEQ_WB;
          end
        end
        STATE_SEQ_WB: begin
          // One WB cycle only, whether or not flush suppressed the write.
          state <= STATE_SEQ_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= STATE_SEQ_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // ------------------------------------------------------------------------
  // Performance counters: saturate at all-ones; only reset clears them.
  // perf_ops counts every WB cycle, including a WB whose write was flushed.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_busy <= '0;
      perf_ops  <= '0;
    end else begin
      if (busy && (perf_busy != '1)) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if ((state == STATE_SEQ_WB) && (perf_ops != '1)) begin
        perf_ops <= perf_ops + 16'd1;
      end
    end
  end
`endif

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer. The reference model tracks
//   each op as "accepted t cycles ago with latency L". Every expected output
//   follows from simple arithmetic on t and L:
//     busy = 1 <= t <= L+1
//     alu_start = t == 1
//     write_enable = t == L+1 and no flush
//   Directed scenarios come first, followed by a randomized run.
//   Build with +define+ALU_SEQ_PERF_EN to also check the perf counters.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_op;
  logic [2:0] req_rd;
  logic [4:0] alu_op;
  logic       alu_start;
  logic       write_enable;
  logic [2:0] wr_addr;
  logic       busy;
  logic       illegal_op;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] perf_busy;
  logic [15:0] perf_ops;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rd       (req_rd),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .write_enable (write_enable),
    .wr_addr      (wr_addr),
    .busy         (busy),
    .illegal_op   (illegal_op)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_busy    (perf_busy),
    .perf_ops     (perf_ops)
`endif
  );

  int n_tests  = 0;
  int n_failed = 0;
  int cyc      = 0;
  int obs_we   = 0;   // write_enable pulses seen since last cleared

  // Reference model state
  bit         m_active;
  int         m_t;
  int         m_lat;
  logic [4:0] m_alu_op;
  logic [2:0] m_wr_addr;
  bit         m_illegal;
  longint     m_perf_busy;
  longint     m_perf_ops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ALU cycles an op needs; 0 marks an op code the ALU does not implement.
  function automatic int lat_of(input logic [4:0] op);
    if (op == OP_DIVIDE)       return 16;
    else if (op == OP_MULTIPLY) return 4;
    else if (op <= OP_LUI)      return 1;
    else                        return 0;
  endfunction

  // One clock cycle: drive inputs, check every output against the model,
  // clock the DUT, then advance the model with the same inputs.
  task automatic step(input logic rst_v, input logic fl, input logic v,
                      input logic [4:0] op, input logic [2:0] rd);
    bit e_busy;
    bit e_we;
    reset = rst_v; flush = fl; req_valid = v; req_op = op; req_rd = rd;
    #1;
    e_busy = m_active;
    e_we   = m_active && (m_t == m_lat + 1) && !fl;
    check("busy",         32'(busy),         32'(e_busy));
    check("alu_start",    32'(alu_start),    32'(m_active && (m_t == 1)));
    check("write_enable", 32'(write_enable), 32'(e_we));
    check("req_ready",    32'(req_ready),    32'(!m_active && !fl));
    check("alu_op",       32'(alu_op),       32'(m_alu_op));
    check("wr_addr",      32'(wr_addr),      32'(m_wr_addr));
    check("illegal_op",   32'(illegal_op),   32'(m_illegal));
`ifdef ALU_SEQ_PERF_EN
    check("perf_busy",    perf_busy,         32'(m_perf_busy));
    check("perf_ops",     32'(perf_ops),     32'(m_perf_ops));
`endif
    if (write_enable === 1'b1) obs_we++;
    @(posedge clk);
    if (!rst_v) begin
      m_active = 0; m_alu_op = '0; m_wr_addr = '0; m_illegal = 0;
      m_perf_busy = 0; m_perf_ops = 0;
    end else begin
      m_illegal = 0;
      if (e_busy && m_perf_busy < 64'hFFFF_FFFF) m_perf_busy++;
      if (m_active) begin
        if (m_t == m_lat + 1 && m_perf_ops < 64'hFFFF) m_perf_ops++;
        if (fl || m_t == m_lat + 1) m_active = 0;
        else m_t++;
      end else if (v && !fl) begin
        m_alu_op  = op;
        m_wr_addr = rd;
        if (lat_of(op) != 0) begin
          m_active = 1; m_t = 1; m_lat = lat_of(op);
        end else begin
          m_illegal = 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 5'h00, 3'd0);
  endtask

  // Issue an op. Once it is accepted, raise flush at t == flush_at
  // (0 = never) or reset at t == rst_at (0 = never). Then run until idle.
  task automatic run_op(input logic [4:0] op, input logic [2:0] rd,
                        input int flush_at, input int rst_at);
    step(1'b1, 1'b0, 1'b1, op, rd);
    for (int t = 1; t <= 20; t++) begin
      step((rst_at == t) ? 1'b0 : 1'b1, (flush_at == t) ? 1'b1 : 1'b0,
           1'b0, 5'h00, 3'd0);
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0;
    m_active = 0; m_t = 0; m_lat = 0; m_alu_op = '0; m_wr_addr = '0;
    m_illegal = 0; m_perf_busy = 0; m_perf_ops = 0;
    // Bring the DUT out of its unknown power-up state before checking.
    @(negedge clk); @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 5'h00, 3'd0);   // reset values checked here
    idle(2);

    // ADD rd=2, then DIVIDE rd=5 (16 cycles)
    obs_we = 0;
    run_op(OP_ADD, 3'd2, 0, 0);
    check("add_write_count", 32'(obs_we), 32'd1);
    obs_we = 0;
    run_op(OP_DIVIDE, 3'd5, 0, 0);
    check("div_write_count", 32'(obs_we), 32'd1);
`ifdef ALU_SEQ_PERF_EN
    check("perf_busy_add_div", perf_busy, 32'd19);
    check("perf_ops_add_div", 32'(perf_ops), 32'd2);
`endif

    // Divide flushed in its 8th EXEC cycle: no write
    obs_we = 0;
    run_op(OP_DIVIDE, 3'd6, 8, 0);
    check("div_flush_no_write", 32'(obs_we), 32'd0);

    // Multiply flushed exactly in WB (t = L+1 = 5): write suppressed
    obs_we = 0;
    run_op(OP_MULTIPLY, 3'd3, 5, 0);
    check("wb_flush_no_write", 32'(obs_we), 32'd0);

    // Reset during multiply EXEC, then a normal op
    obs_we = 0;
    run_op(OP_MULTIPLY, 3'd7, 0, 2);
    check("mul_reset_no_write", 32'(obs_we), 32'd0);
    run_op(OP_SUB, 3'd4, 0, 0);
    check("after_reset_write", 32'(obs_we), 32'd1);

    // Unknown op: illegal pulse, no EXEC, no write
    obs_we = 0;
    step(1'b1, 1'b0, 1'b1, 5'h1F, 3'd1);
    idle(3);
    check("illegal_no_write", 32'(obs_we), 32'd0);

    // flush together with req_valid in IDLE: not accepted
    step(1'b1, 1'b1, 1'b1, OP_ADD, 3'd6);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic       r_rst;
      logic       r_fl;
      logic       r_v;
      logic [4:0] r_op;
      int         sel;
      r_rst = ($urandom_range(0, 99) != 0);
      r_fl  = ($urandom_range(0, 24) == 0);
      r_v   = ($urandom_range(0, 9) < 6);
      sel   = $urandom_range(0, 9);
      if (sel <= 5)      r_op = 5'($urandom_range(0, 11));
      else if (sel == 6) r_op = OP_MULTIPLY;
      else if (sel == 7) r_op = OP_DIVIDE;
      else               r_op = 5'($urandom_range(0, 31));
      step(r_rst, r_fl, r_v, r_op, 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule : tb_alu_op_sequencer
